// File: rtl/dlfloat_operand_loader.sv
// Assembles byte-serial DLFloat16 operand pairs (A lo, A hi, B lo, B hi) into a show-ahead
// FIFO feeding a MAC. Optional push-time subnormal flush: define DLFLOAT_LOADER_SCREEN_EN.
module dlfloat_operand_loader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  input  logic                        frame_abort,
  input  logic                        acc_clr,
  output logic [15:0]                 op_a,
  output logic [15:0]                 op_b,
  output logic                        op_clr,
  output logic                        op_valid,
  input  logic                        op_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {A_LO, A_HI, B_LO, B_HI} asm_state_t;

  asm_state_t       state_q, state_d;
  logic [15:0]      a_q;
  logic [7:0]       b_lo_q;
  logic             sticky_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [32:0]      mem_q [FIFO_DEPTH];

  logic        full, accept, push, pop, clr_tag;
  logic [15:0] push_a, push_b;
  logic [32:0] head;

`ifdef DLFLOAT_LOADER_SCREEN_EN
  // Zero-exponent non-zero encodings are flushed; 0xFFFF has a full exponent and passes.
  function automatic logic [15:0] screen(input logic [15:0] x);
    return ((x[14:9] == 6'd0) && (x != 16'h0000)) ? 16'h0000 : x;
  endfunction
  assign push_a = screen(a_q);
  assign push_b = screen({byte_in, b_lo_q});
`else
  assign push_a = a_q;
  assign push_b = {byte_in, b_lo_q};
`endif

  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  // Stall only the pair-completing byte; pops free space one edge later.
  assign byte_ready = !((state_q == B_HI) && full);
  assign accept     = byte_valid && byte_ready;
  assign push       = accept && (state_q == B_HI) && !frame_abort;
  assign op_valid   = (level_q != '0);
  assign pop        = op_valid && op_ready;
  assign clr_tag    = sticky_q | acc_clr;
  assign fifo_level = level_q;

  assign head   = mem_q[rd_ptr_q];
  assign op_a   = op_valid ? head[31:16] : 16'h0000;
  assign op_b   = op_valid ? head[15:0]  : 16'h0000;
  assign op_clr = op_valid & head[32];

  always_comb begin
    state_d = state_q;
    if (frame_abort) begin
      state_d = A_LO;
    end else if (accept) begin
      unique case (state_q)
        A_LO:    state_d = A_HI;
        A_HI:    state_d = B_LO;
        B_LO:    state_d = B_HI;
        default: state_d = A_LO;
      endcase
    end
  end

  // Assembly stage: FSM and held partial-pair bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= A_LO;
      a_q     <= '0;
      b_lo_q  <= '0;
    end else begin
      state_q <= state_d;
      if (frame_abort) begin
        a_q    <= '0;
        b_lo_q <= '0;
      end else if (accept) begin
        unique case (state_q)
          A_LO:    a_q[7:0]  <= byte_in;
          A_HI:    a_q[15:8] <= byte_in;
          B_LO:    b_lo_q    <= byte_in;
          default: ;
        endcase
      end
    end
  end

  // FIFO stage: pair storage is data-only and needs no reset because outputs are gated by op_valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {clr_tag, push_a, push_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: ;
      endcase
      if (push)         sticky_q <= 1'b0;
      else if (acc_clr) sticky_q <= 1'b1;
    end
  end

endmodule
